// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline interlock / flush sequencer.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam logic [1:0]       STALL_EX  = 2'd2;
  localparam logic [1:0]       STALL_MEM = 2'd1;
  localparam logic [REG_W-1:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard-control bundle between the datapath (master) and the interlock block (slave).
interface hazard_controller_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ra_id;
  logic [REG_W-1:0] rb_id;
  logic             ra_used_id;
  logic             rb_used_id;
  logic [REG_W-1:0] rw_ex;
  logic [REG_W-1:0] rw_mem;
  logic             wr_en_ex;
  logic             wr_en_mem;
  logic             branch_taken_ex;
  logic             cnt_clr;
  logic             hold_pc;
  logic             hold_ifid;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ra_id, rb_id, ra_used_id, rb_used_id, rw_ex, rw_mem,
           wr_en_ex, wr_en_mem, branch_taken_ex, cnt_clr,
    input  hold_pc, hold_ifid, bubble_idex, flush_ifid, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  ra_id, rb_id, ra_used_id, rb_used_id, rw_ex, rw_mem,
           wr_en_ex, wr_en_mem, branch_taken_ex, cnt_clr,
    output hold_pc, hold_ifid, bubble_idex, flush_ifid, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// RAW interlock and taken-branch flush sequencer for the 5-stage no-forwarding datapath.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  hz_state_t  state, state_nxt;
  logic [1:0] remaining, remaining_nxt;
  logic [1:0] need;
  logic       match_ex, match_mem;
  logic       hold, bubble, flush, stall_inc, flush_inc;

  function automatic logic producer_match(
    input logic [REG_W-1:0] rw,
    input logic             wr_en,
    input logic [REG_W-1:0] ra,
    input logic [REG_W-1:0] rb,
    input logic             ra_used,
    input logic             rb_used
  );
    logic hit;
    hit = (ra_used && (ra == rw)) || (rb_used && (rb == rw));
    return wr_en && hit && !(R0_ZERO && (rw == REG_ZERO));
  endfunction

  // WB producers are covered by the write-first register file, so only EX and MEM matter
  assign match_ex  = producer_match(hz.rw_ex,  hz.wr_en_ex,  hz.ra_id, hz.rb_id,
                                    hz.ra_used_id, hz.rb_used_id);
  assign match_mem = producer_match(hz.rw_mem, hz.wr_en_mem, hz.ra_id, hz.rb_id,
                                    hz.ra_used_id, hz.rb_used_id);

  always_comb begin
    need = 2'd0;
    if (match_ex) begin
      need = STALL_EX;
    end else if (match_mem) begin
      need = STALL_MEM;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      remaining <= 2'd0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    hold          = 1'b0;
    bubble        = 1'b0;
    flush         = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    // a taken branch wins in either state and abandons any stall in progress
    if (hz.branch_taken_ex) begin
      flush         = 1'b1;
      bubble        = 1'b1;
      flush_inc     = 1'b1;
      state_nxt     = RUN;
      remaining_nxt = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need != 2'd0) begin
            hold      = 1'b1;
            bubble    = 1'b1;
            stall_inc = 1'b1;
            if (need == STALL_EX) begin
              remaining_nxt = STALL_EX - 2'd1;
              state_nxt     = STALL;
            end
          end
        end
        STALL: begin
          hold          = 1'b1;
          bubble        = 1'b1;
          stall_inc     = 1'b1;
          remaining_nxt = (remaining == 2'd0) ? 2'd0 : remaining - 2'd1;
          state_nxt     = (remaining <= 2'd1) ? RUN : STALL;
        end
        default: begin
          state_nxt     = RUN;
          remaining_nxt = 2'd0;
        end
      endcase
    end
  end

  // Gated by reset so the pipeline sees no hold/flush while it is being cleared
  assign hz.hold_pc     = hold   & reset;
  assign hz.hold_ifid   = hold   & reset;
  assign hz.bubble_idex = bubble & reset;
  assign hz.flush_ifid  = flush  & reset;
  assign hz.busy        = (state == STALL);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (hz.cnt_clr),
    .inc   (stall_inc),
    .q     (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (hz.cnt_clr),
    .inc   (flush_inc),
    .q     (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench: three controller variants (default, R0_ZERO=0, CNT_W=4) driven in lockstep against an owed-stall model.
module tb_hazard_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] ra, rb, rwe, rwm;
  logic       rau, rbu, wee, wem, br, clr;

  hazard_controller_if #(.CNT_W(16)) if_a ();
  hazard_controller_if #(.CNT_W(16)) if_b ();
  hazard_controller_if #(.CNT_W(4))  if_c ();

  assign if_a.ra_id = ra;  assign if_b.ra_id = ra;  assign if_c.ra_id = ra;
  assign if_a.rb_id = rb;  assign if_b.rb_id = rb;  assign if_c.rb_id = rb;
  assign if_a.ra_used_id = rau;  assign if_b.ra_used_id = rau;  assign if_c.ra_used_id = rau;
  assign if_a.rb_used_id = rbu;  assign if_b.rb_used_id = rbu;  assign if_c.rb_used_id = rbu;
  assign if_a.rw_ex = rwe;   assign if_b.rw_ex = rwe;   assign if_c.rw_ex = rwe;
  assign if_a.rw_mem = rwm;  assign if_b.rw_mem = rwm;  assign if_c.rw_mem = rwm;
  assign if_a.wr_en_ex = wee;   assign if_b.wr_en_ex = wee;   assign if_c.wr_en_ex = wee;
  assign if_a.wr_en_mem = wem;  assign if_b.wr_en_mem = wem;  assign if_c.wr_en_mem = wem;
  assign if_a.branch_taken_ex = br;  assign if_b.branch_taken_ex = br;  assign if_c.branch_taken_ex = br;
  assign if_a.cnt_clr = clr;  assign if_b.cnt_clr = clr;  assign if_c.cnt_clr = clr;

  hazard_controller #(.CNT_W(16), .R0_ZERO(1'b1)) dut_a (.clock(clock), .reset(reset), .hz(if_a.slave));
  hazard_controller #(.CNT_W(16), .R0_ZERO(1'b0)) dut_b (.clock(clock), .reset(reset), .hz(if_b.slave));
  hazard_controller #(.CNT_W(4),  .R0_ZERO(1'b1)) dut_c (.clock(clock), .reset(reset), .hz(if_c.slave));

  logic [4:0]  ctl   [3];
  logic [15:0] obs_s [3];
  logic [15:0] obs_f [3];
  assign ctl[0] = {if_a.hold_pc, if_a.hold_ifid, if_a.bubble_idex, if_a.flush_ifid, if_a.busy};
  assign ctl[1] = {if_b.hold_pc, if_b.hold_ifid, if_b.bubble_idex, if_b.flush_ifid, if_b.busy};
  assign ctl[2] = {if_c.hold_pc, if_c.hold_ifid, if_c.bubble_idex, if_c.flush_ifid, if_c.busy};
  assign obs_s[0] = if_a.stall_cnt;  assign obs_f[0] = if_a.flush_cnt;
  assign obs_s[1] = if_b.stall_cnt;  assign obs_f[1] = if_b.flush_cnt;
  assign obs_s[2] = {12'd0, if_c.stall_cnt};  assign obs_f[2] = {12'd0, if_c.flush_cnt};

  // Model: per variant, how many more forced stall cycles are owed, plus integer counters
  int owed [3];
  int scnt [3];
  int fcnt [3];
  int cmax [3] = '{65535, 65535, 15};
  bit r0z  [3] = '{1'b1, 1'b0, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int need_of(bit zero_hw);
    bit m_ex, m_mem;
    m_ex  = wee && !(zero_hw && rwe == 5'd0) && ((rau && ra == rwe) || (rbu && rb == rwe));
    m_mem = wem && !(zero_hw && rwm == 5'd0) && ((rau && ra == rwm) || (rbu && rb == rwm));
    return m_ex ? 2 : (m_mem ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      owed[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
  endtask

  // Called at posedge+1 with inputs set; checks before the next edge, then advances.
  task automatic step(input string tag);
    bit e_hold, e_bub, e_fl, e_busy, s_inc, f_inc;
    int nd;
    #3;
    for (int k = 0; k < 3; k++) begin
      e_hold = 0; e_bub = 0; e_fl = 0; e_busy = 0; s_inc = 0; f_inc = 0;
      if (reset) begin
        e_busy = owed[k] > 0;
        if (br) begin
          e_fl = 1; e_bub = 1; f_inc = 1; owed[k] = 0;
        end else if (owed[k] > 0) begin
          e_hold = 1; e_bub = 1; s_inc = 1; owed[k]--;
        end else begin
          nd = need_of(r0z[k]);
          if (nd > 0) begin
            e_hold = 1; e_bub = 1; s_inc = 1; owed[k] = nd - 1;
          end
        end
      end
      check($sformatf("%s dut%0d ctl", tag, k), 32'(ctl[k]), {27'd0, e_hold, e_hold, e_bub, e_fl, e_busy});
      check($sformatf("%s dut%0d stall_cnt", tag, k), 32'(obs_s[k]), 32'(scnt[k]));
      check($sformatf("%s dut%0d flush_cnt", tag, k), 32'(obs_f[k]), 32'(fcnt[k]));
      if (!reset || clr) begin
        scnt[k] = 0; fcnt[k] = 0;
        if (!reset) owed[k] = 0;
      end else begin
        if (s_inc && scnt[k] < cmax[k]) scnt[k]++;
        if (f_inc && fcnt[k] < cmax[k]) fcnt[k]++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ra = 0; rb = 0; rwe = 0; rwm = 0;
    rau = 0; rbu = 0; wee = 0; wem = 0; br = 0; clr = 0;
  endtask

  task automatic clear_counters();
    idle();
    clr = 1;
    step("clr");
    clr = 0;
  endtask

  task automatic ex_hazard_ra3();
    idle();
    rwe = 3; wee = 1; ra = 3; rau = 1;
  endtask

  initial begin
    idle();
    reset = 0;
    model_reset();
    @(posedge clock);
    #1;
    step("in_reset");
    reset = 1;
    step("after_reset");

    // EX producer: two stall cycles, then the producer drifts to MEM and WB
    clear_counters();
    ex_hazard_ra3();
    step("t1_c1");
    idle(); ra = 3; rau = 1; rwm = 3; wem = 1;
    step("t1_c2");
    idle(); ra = 3; rau = 1;
    step("t1_c3");
    check("t1 stall_cnt", 32'(obs_s[0]), 32'd2);

    // MEM producer on rb: single stall
    clear_counters();
    rwm = 7; wem = 1; rb = 7; rbu = 1; rwe = 2; wee = 1;
    step("t2_c1");
    idle(); rb = 7; rbu = 1;
    step("t2_c2");
    check("t2 stall_cnt", 32'(obs_s[0]), 32'd1);

    // r0 producer: ignored with R0_ZERO=1, two stalls with R0_ZERO=0
    clear_counters();
    rwe = 0; wee = 1; ra = 0; rau = 1;
    step("t3_c1");
    idle(); ra = 0; rau = 1;
    step("t3_c2");
    step("t3_c3");
    check("t3 r0zero stall_cnt", 32'(obs_s[0]), 32'd0);
    check("t3 no_r0zero stall_cnt", 32'(obs_s[1]), 32'd2);

    // Branch beats an EX hazard
    clear_counters();
    ex_hazard_ra3();
    br = 1;
    step("t4_c1");
    idle();
    step("t4_c2");
    check("t4 flush_cnt", 32'(obs_f[0]), 32'd1);
    check("t4 stall_cnt", 32'(obs_s[0]), 32'd0);

    // Async reset in the middle of a stall
    ex_hazard_ra3();
    step("t5_c1");
    #2;
    reset = 0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5 dut%0d ctl in reset", k), 32'(ctl[k]), 32'd0);
      check($sformatf("t5 dut%0d stall_cnt in reset", k), 32'(obs_s[k]), 32'd0);
    end
    @(posedge clock);
    #1;
    idle();
    reset = 1;
    step("t5_release");

    // Saturation of the 4-bit variant, then clear beats a concurrent stall
    ex_hazard_ra3();
    for (int i = 0; i < 40; i++) step("t6_sat");
    check("t6 sat stall_cnt", 32'(obs_s[2]), 32'd15);
    check("t6 wide stall_cnt", 32'(obs_s[0]), 32'd40);
    clr = 1;
    step("t6_clr");
    clr = 0;
    check("t6 clr narrow", 32'(obs_s[2]), 32'd0);
    check("t6 clr wide", 32'(obs_s[0]), 32'd0);
    idle();
    step("t6_idle");

    // Random traffic over a small register window to provoke frequent matches
    for (int i = 0; i < 400; i++) begin
      ra  = 5'($urandom_range(0, 3));
      rb  = 5'($urandom_range(0, 3));
      rwe = 5'($urandom_range(0, 3));
      rwm = 5'($urandom_range(0, 3));
      rau = 1'($urandom);
      rbu = 1'($urandom);
      wee = 1'($urandom);
      wem = 1'($urandom);
      br  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 31) == 0);
      step("rand");
    end
    idle();
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
